// File: rtl/mips_mc_control_if.sv
// rtl/mips_mc_control_if.sv - control/datapath bundle for the multicycle MIPS controller
interface mips_mc_control_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic [3:0] ALUctl;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic [3:0] State;

  modport master (
    input  Op, Funct, Zero,
    output ALUctl, ALUSrcA, ALUSrcB, PCSource, PCWrite, IorD,
           MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, State
  );

  modport slave (
    output Op, Funct, Zero,
    input  ALUctl, ALUSrcA, ALUSrcB, PCSource, PCWrite, IorD,
           MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, State
  );
endinterface

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multicycle MIPS main-control FSM (Moore, one state register)
module mips_mc_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input  logic              clk,
  input  logic              reset,
  mips_mc_control_if.master bus
);

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RTYPEWB = 4'd7,
    BEQ     = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0] funct_ctl;
  logic       funct_ok;

  logic [3:0] alu_ctl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pcw_uncond;
  logic       pcw_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Unsupported Funct codes execute as ADD but must not write the register file.
  always_comb begin
    funct_ctl = ALU_ADD;
    funct_ok  = 1'b1;
    case (bus.Funct)
      6'h24:   funct_ctl = ALU_AND;
      6'h25:   funct_ctl = ALU_OR;
      6'h20:   funct_ctl = ALU_ADD;
      6'h22:   funct_ctl = ALU_SUB;
      6'h2A:   funct_ctl = ALU_SLT;
      6'h27:   funct_ctl = ALU_NOR;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXEC;
          OP_BEQ:       state_next = BEQ;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR: begin
        if (bus.Op == OP_LW)      state_next = MEMRD;
        else if (bus.Op == OP_SW) state_next = MEMWR;
        else                      state_next = FETCH;
      end
      MEMRD:   state_next = MEMWB;
      EXEC:    state_next = RTYPEWB;
      ADDIEX:  state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    alu_ctl    = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    pc_source  = 2'd0;
    pcw_uncond = 1'b0;
    pcw_cond   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    case (state)
      FETCH: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        alu_src_b  = 2'd1;
        pcw_uncond = 1'b1;
      end
      DECODE: alu_src_b = 2'd3;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_ctl   = funct_ctl;
      end
      RTYPEWB: begin
        reg_dst   = 1'b1;
        reg_write = funct_ok;
      end
      BEQ: begin
        alu_src_a = 1'b1;
        alu_ctl   = ALU_SUB;
        pc_source = 2'd1;
        pcw_cond  = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP: begin
        pc_source  = 2'd2;
        pcw_uncond = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are masked by reset directly so they drop without waiting for a clock edge.
  assign bus.PCWrite  = ~reset & (pcw_uncond | (pcw_cond & bus.Zero));
  assign bus.MemRead  = ~reset & mem_read;
  assign bus.MemWrite = ~reset & mem_write;
  assign bus.IRWrite  = ~reset & ir_write;
  assign bus.RegWrite = ~reset & reg_write;

  assign bus.ALUctl   = alu_ctl;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.PCSource = pc_source;
  assign bus.IorD     = iord;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.RegDst   = reg_dst;
  assign bus.State    = state;

endmodule

// File: tb/tb_mips_mc_control.sv
// tb/tb_mips_mc_control.sv - directed self-checking bench for mips_mc_control
module tb_mips_mc_control;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mips_mc_control_if bus ();

  mips_mc_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet_writes(input string tag);
    check({tag, "_memwrite"}, 32'(bus.MemWrite), 32'd0);
    check({tag, "_regwrite"}, 32'(bus.RegWrite), 32'd0);
  endtask

  logic [5:0] rfunct [6] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27};
  logic [3:0] rctl   [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
  logic [3:0] lw_seq [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.Op = 6'h00;
    bus.Funct = 6'h20;
    bus.Zero = 1'b0;

    repeat (3) step();
    check("rst_state", 32'(bus.State), 32'd0);
    check("rst_pcwrite", 32'(bus.PCWrite), 32'd0);
    check("rst_memread", 32'(bus.MemRead), 32'd0);
    check("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    check("rst_irwrite", 32'(bus.IRWrite), 32'd0);
    check("rst_regwrite", 32'(bus.RegWrite), 32'd0);
    check("rst_aluctl", 32'(bus.ALUctl), 32'd2);
    check("rst_alusrcb", 32'(bus.ALUSrcB), 32'd1);
    check("rst_pcsource", 32'(bus.PCSource), 32'd0);

    reset = 1'b0;
    bus.Op = 6'h23;
    #1;
    check("fetch_state", 32'(bus.State), 32'd0);
    check("fetch_memread", 32'(bus.MemRead), 32'd1);
    check("fetch_irwrite", 32'(bus.IRWrite), 32'd1);
    check("fetch_pcwrite", 32'(bus.PCWrite), 32'd1);
    check("fetch_aluctl", 32'(bus.ALUctl), 32'd2);
    check("fetch_iord", 32'(bus.IorD), 32'd0);

    // lw: 0,1,2,3,4,0
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("lw_state%0d", i), 32'(bus.State), 32'(lw_seq[i]));
      check($sformatf("lw_memwrite%0d", i), 32'(bus.MemWrite), 32'd0);
      if (i == 0) check("lw_decode_alusrcb", 32'(bus.ALUSrcB), 32'd3);
      if (i == 1) begin
        check("lw_memadr_alusrca", 32'(bus.ALUSrcA), 32'd1);
        check("lw_memadr_alusrcb", 32'(bus.ALUSrcB), 32'd2);
      end
      if (i == 2) begin
        check("lw_memrd_memread", 32'(bus.MemRead), 32'd1);
        check("lw_memrd_iord", 32'(bus.IorD), 32'd1);
      end
      if (i == 3) begin
        check("lw_memwb_regwrite", 32'(bus.RegWrite), 32'd1);
        check("lw_memwb_memtoreg", 32'(bus.MemtoReg), 32'd1);
        check("lw_memwb_regdst", 32'(bus.RegDst), 32'd0);
      end
    end

    // R-type over all supported Funct codes
    bus.Op = 6'h00;
    for (int i = 0; i < 6; i++) begin
      bus.Funct = rfunct[i];
      step();
      check($sformatf("r%0d_decode", i), 32'(bus.State), 32'd1);
      step();
      check($sformatf("r%0d_exec", i), 32'(bus.State), 32'd6);
      check($sformatf("r%0d_aluctl", i), 32'(bus.ALUctl), 32'(rctl[i]));
      check($sformatf("r%0d_alusrcb", i), 32'(bus.ALUSrcB), 32'd0);
      step();
      check($sformatf("r%0d_wb", i), 32'(bus.State), 32'd7);
      check($sformatf("r%0d_regwrite", i), 32'(bus.RegWrite), 32'd1);
      check($sformatf("r%0d_regdst", i), 32'(bus.RegDst), 32'd1);
      step();
      check($sformatf("r%0d_back", i), 32'(bus.State), 32'd0);
    end

    bus.Funct = 6'h3F;
    step();
    step();
    check("rbad_exec", 32'(bus.State), 32'd6);
    check("rbad_aluctl", 32'(bus.ALUctl), 32'd2);
    step();
    check("rbad_wb", 32'(bus.State), 32'd7);
    check("rbad_regwrite", 32'(bus.RegWrite), 32'd0);
    step();
    check("rbad_back", 32'(bus.State), 32'd0);

    // beq taken then not taken
    bus.Op = 6'h04;
    for (int z = 1; z >= 0; z--) begin
      bus.Zero = z[0];
      step();
      check($sformatf("beq%0d_decode", z), 32'(bus.State), 32'd1);
      check($sformatf("beq%0d_dec_pcwrite", z), 32'(bus.PCWrite), 32'd0);
      step();
      check($sformatf("beq%0d_state", z), 32'(bus.State), 32'd8);
      check($sformatf("beq%0d_aluctl", z), 32'(bus.ALUctl), 32'd6);
      check($sformatf("beq%0d_pcsource", z), 32'(bus.PCSource), 32'd1);
      check($sformatf("beq%0d_pcwrite", z), 32'(bus.PCWrite), 32'(z));
      step();
      check($sformatf("beq%0d_back", z), 32'(bus.State), 32'd0);
    end
    bus.Zero = 1'b0;

    // sw interrupted by reset in MEMADR
    bus.Op = 6'h2B;
    step();
    step();
    check("sw_memadr", 32'(bus.State), 32'd2);
    check("sw_memadr_memwrite", 32'(bus.MemWrite), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("swrst_state", 32'(bus.State), 32'd0);
    check("swrst_memread", 32'(bus.MemRead), 32'd0);
    check("swrst_pcwrite", 32'(bus.PCWrite), 32'd0);
    check_quiet_writes("swrst");
    step();
    check("swrst_hold_state", 32'(bus.State), 32'd0);
    check_quiet_writes("swrst_hold");
    step();
    reset = 1'b0;
    #1;
    check("swrel_memread", 32'(bus.MemRead), 32'd1);
    check("swrel_irwrite", 32'(bus.IRWrite), 32'd1);
    step();
    check("sw_decode", 32'(bus.State), 32'd1);
    step();
    check("sw_memadr2", 32'(bus.State), 32'd2);
    step();
    check("sw_memwr", 32'(bus.State), 32'd5);
    check("sw_memwrite", 32'(bus.MemWrite), 32'd1);
    check("sw_iord", 32'(bus.IorD), 32'd1);
    step();
    check("sw_back", 32'(bus.State), 32'd0);

    // undefined opcode behaves as a 2-cycle NOP
    bus.Op = 6'h3F;
    step();
    check("nop_decode", 32'(bus.State), 32'd1);
    check_quiet_writes("nop_decode");
    step();
    check("nop_back", 32'(bus.State), 32'd0);

    // addi
    bus.Op = 6'h08;
    step();
    step();
    check("addi_ex", 32'(bus.State), 32'd9);
    check("addi_ex_alusrcb", 32'(bus.ALUSrcB), 32'd2);
    step();
    check("addi_wb", 32'(bus.State), 32'd10);
    check("addi_wb_regwrite", 32'(bus.RegWrite), 32'd1);
    check("addi_wb_memtoreg", 32'(bus.MemtoReg), 32'd0);
    step();
    check("addi_back", 32'(bus.State), 32'd0);

    // jump
    bus.Op = 6'h02;
    step();
    step();
    check("j_state", 32'(bus.State), 32'd11);
    check("j_pcsource", 32'(bus.PCSource), 32'd2);
    check("j_pcwrite", 32'(bus.PCWrite), 32'd1);
    check_quiet_writes("j");
    step();
    check("j_back", 32'(bus.State), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
